// File: rtl/blk_vote_gen_pkg.sv
// Shared constants and types for the per-block dark-pixel vote path.
// BLK_VOTE_HYST_EN (optional) enables hysteresis classification in blk_vote_gen.
package blk_pkg;

  // BT.601-style luma weights, scaled by 256
  localparam int LUMA_KR    = 77;
  localparam int LUMA_KG    = 150;
  localparam int LUMA_KB    = 29;
  // input-to-output delay of hs/de and of the vote strobe
  localparam int LAT        = 3;
  // threshold widening applied after a dark pixel (hysteresis build only)
  localparam int HYST_DELTA = 16;

  typedef logic [7:0]  vote_t;
  typedef logic [15:0] blk_idx_t;

  // Widened threshold th + HYST_DELTA, clamped at 255
  function automatic logic [7:0] hyst_th(input logic [7:0] th);
    logic [8:0] s;
    s = 9'(th) + 9'(HYST_DELTA);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/blk_vote_gen_luma_pipe.sv
// Two-stage RGB -> 8-bit luma pipeline with hs/de delayed to match.
// Stage 1 registers the three weighted products, stage 2 the scaled sum.
module luma_pipe
  import blk_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       hs,
  input  logic       de,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] luma,
  output logic       hs_d,
  output logic       de_d
);

  logic [15:0] pr_reg, pg_reg, pb_reg;
  logic        hs1_reg, de1_reg;
  logic [17:0] sum;
  logic [7:0]  luma_next;
  logic [7:0]  luma_reg;
  logic        hs2_reg, de2_reg;

  // Stage 1: weighted colour products, registered with their timing bits
  always_ff @(posedge clk) begin
    if (srst) begin
      pr_reg  <= '0;
      pg_reg  <= '0;
      pb_reg  <= '0;
      hs1_reg <= 1'b0;
      de1_reg <= 1'b0;
    end else begin
      pr_reg  <= 16'(r) * 16'(LUMA_KR);
      pg_reg  <= 16'(g) * 16'(LUMA_KG);
      pb_reg  <= 16'(b) * 16'(LUMA_KB);
      hs1_reg <= hs;
      de1_reg <= de;
    end
  end

  // Sum of products and divide by 256 (weights sum to 256, so luma fits 8 bits)
  always_comb begin
    sum       = 18'(pr_reg) + 18'(pg_reg) + 18'(pb_reg);
    luma_next = 8'(sum >> 8);
  end

  // Stage 2: registered luma with its timing bits
  always_ff @(posedge clk) begin
    if (srst) begin
      luma_reg <= '0;
      hs2_reg  <= 1'b0;
      de2_reg  <= 1'b0;
    end else begin
      luma_reg <= luma_next;
      hs2_reg  <= hs1_reg;
      de2_reg  <= de1_reg;
    end
  end

  assign luma = luma_reg;
  assign hs_d = hs2_reg;
  assign de_d = de2_reg;

endmodule

// File: rtl/blk_vote_gen.sv
// Per-block dark-pixel vote generator: counts pixels darker than a runtime
// threshold over blocks of KH pixels and emits one vote word per block.
// Optional macro BLK_VOTE_HYST_EN: hysteresis on the dark classification.
module blk_vote_gen
  import blk_pkg::*;
#(
  parameter int HP = 1920,
  parameter int KH = 10,
  parameter int TH = 96
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [7:0]  r_i,
  input  logic [7:0]  g_i,
  input  logic [7:0]  b_i,
  input  logic [7:0]  th_i,
  output logic        hs_o,
  output logic        de_o,
  output logic [7:0]  wd_o,
  output logic        wd_vld_o,
  output logic [15:0] hb_o
);

  // Reject parameter sets the counters cannot represent
  if (KH < 1 || KH > 255 || HP < 1 || LAT != 3) begin : g_bad_param
    $error("blk_vote_gen: illegal parameter set");
  end

  logic [7:0] luma2;
  logic       hs2, de2;

  logic       hs_prev_reg;
  logic [7:0] th_reg, th1_reg, th2_reg;
  logic       hs3_reg, de3_reg;

  vote_t      cnt_reg, cnt_next;
  logic [7:0] h_reg, h_next;
  blk_idx_t   hb_reg, hb_next;
  vote_t      wd_reg, wd_next;
  blk_idx_t   hbo_reg, hbo_next;
  logic       vld_reg, vld_next;

  logic       dark;
  logic       line_end;

  luma_pipe u_luma (
    .clk  (clk_i),
    .srst (rst_i),
    .hs   (hs_i),
    .de   (de_i),
    .r    (r_i),
    .g    (g_i),
    .b    (b_i),
    .luma (luma2),
    .hs_d (hs2),
    .de_d (de2)
  );

  // Threshold capture on hs rise; the value in force travels with each pixel
  // so pixels already in flight keep the threshold they entered with.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_prev_reg <= 1'b0;
      th_reg      <= 8'(TH);
      th1_reg     <= '0;
      th2_reg     <= '0;
    end else begin
      hs_prev_reg <= hs_i;
      if (hs_i && !hs_prev_reg) begin
        th_reg <= th_i;
      end
      th1_reg <= th_reg;
      th2_reg <= th1_reg;
    end
  end

`ifdef BLK_VOTE_HYST_EN
  logic prev_dark_reg, prev_dark_next;

  // Dark classification with widened threshold after a dark pixel
  always_comb begin
    dark = 1'b0;
    if (de2 && ((luma2 < th2_reg) || (prev_dark_reg && (luma2 < hyst_th(th2_reg))))) begin
      dark = 1'b1;
    end
  end

  // Previous-pixel flag follows active pixels and clears at line end
  always_comb begin
    prev_dark_next = prev_dark_reg;
    if (de2) begin
      prev_dark_next = dark;
    end else if (line_end) begin
      prev_dark_next = 1'b0;
    end
  end

  // Previous-pixel flag register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_dark_reg <= 1'b0;
    end else begin
      prev_dark_reg <= prev_dark_next;
    end
  end
`else
  // Plain dark classification against the threshold
  always_comb begin
    dark = 1'b0;
    if (de2 && (luma2 < th2_reg)) begin
      dark = 1'b1;
    end
  end
`endif

  // de3_reg is stage-2 de one cycle late, so this marks the stage-2 de fall
  assign line_end = de3_reg && !de2;

  // Block accumulator: count, close full blocks, flush partial ones at line end
  always_comb begin
    cnt_next = cnt_reg;
    h_next   = h_reg;
    hb_next  = hb_reg;
    wd_next  = wd_reg;
    hbo_next = hbo_reg;
    vld_next = 1'b0;
    if (de2) begin
      if (h_reg == 8'(KH - 1)) begin
        wd_next  = cnt_reg + vote_t'(dark);
        hbo_next = hb_reg;
        vld_next = 1'b1;
        cnt_next = '0;
        h_next   = '0;
        hb_next  = hb_reg + 16'd1;
      end else begin
        cnt_next = cnt_reg + vote_t'(dark);
        h_next   = h_reg + 8'd1;
      end
    end else if (line_end) begin
      if (h_reg != 8'd0) begin
        wd_next  = cnt_reg;
        hbo_next = hb_reg;
        vld_next = 1'b1;
      end
      cnt_next = '0;
      h_next   = '0;
      hb_next  = '0;
    end
  end

  // Stage 3 registers: accumulator state, vote outputs and delayed timing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
      h_reg   <= '0;
      hb_reg  <= '0;
      wd_reg  <= '0;
      hbo_reg <= '0;
      vld_reg <= 1'b0;
      hs3_reg <= 1'b0;
      de3_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      h_reg   <= h_next;
      hb_reg  <= hb_next;
      wd_reg  <= wd_next;
      hbo_reg <= hbo_next;
      vld_reg <= vld_next;
      hs3_reg <= hs2;
      de3_reg <= de2;
    end
  end

  assign hs_o     = hs3_reg;
  assign de_o     = de3_reg;
  assign wd_o     = wd_reg;
  assign wd_vld_o = vld_reg;
  assign hb_o     = hbo_reg;

endmodule

// File: tb/tb_blk_vote_gen.sv
// Self-checking bench for blk_vote_gen: line-level behavioural model with a
// per-cycle compare process, plus literal checks for the directed scenarios.
module tb_blk_vote_gen;

  localparam int KH = 10;
  localparam int TH = 96;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, hs_i = 1'b0, de_i = 1'b0;
  logic [7:0]  r_i = '0, g_i = '0, b_i = '0, th_i = 8'd96;
  logic        hs_o, de_o, wd_vld_o;
  logic [7:0]  wd_o;
  logic [15:0] hb_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int th_drv = 96;

  // input history per clock edge
  bit hist_rst[int];
  bit hist_de[int];
  bit hist_hs[int];
  // expected strobes keyed by the edge after which they are visible
  int exp_wd[int];
  int exp_hb[int];

  // line-level model state
  int th_model = TH;
  bit hs_prev_m = 1'b0;
  int run_len = 0;
  int run_cnt = 0;
  int run_blk = 0;
  bit run_prev = 1'b0;

  // observed strobes and pixel edges for the directed literal checks
  int obs_wd[$];
  int obs_hb[$];
  int obs_edge[$];
  int px_edge[$];

  blk_vote_gen #(.HP(25), .KH(KH), .TH(TH)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .hs_i     (hs_i),
    .de_i     (de_i),
    .r_i      (r_i),
    .g_i      (g_i),
    .b_i      (b_i),
    .th_i     (th_i),
    .hs_o     (hs_o),
    .de_o     (de_o),
    .wd_o     (wd_o),
    .wd_vld_o (wd_vld_o),
    .hb_o     (hb_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Behavioural model: per pixel classify from luma, close blocks every KH
  // pixels of a de run, flush the remainder when the run ends.
  task automatic model_step(input bit rst, input bit hs, input bit de,
                            input int r, input int g, input int b, input int th);
    int th_use, luma, lim;
    bit dark;
    if (rst) begin
      th_model = TH; hs_prev_m = 1'b0;
      run_len = 0; run_cnt = 0; run_blk = 0; run_prev = 1'b0;
      return;
    end
    th_use = th_model;
    if (hs && !hs_prev_m) th_model = th;
    hs_prev_m = hs;
    if (de) begin
      luma = (77 * r + 150 * g + 29 * b) / 256;
      dark = (luma < th_use);
`ifdef BLK_VOTE_HYST_EN
      lim = (th_use + 16 > 255) ? 255 : th_use + 16;
      if (run_prev && luma < lim) dark = 1'b1;
`else
      lim = th_use;
`endif
      run_prev = dark;
      run_cnt += int'(dark);
      run_len++;
      if (run_len % KH == 0) begin
        exp_wd[edge_n + 2] = run_cnt;
        exp_hb[edge_n + 2] = run_blk;
        run_blk++;
        run_cnt = 0;
      end
    end else if (run_len > 0) begin
      if (run_len % KH != 0) begin
        exp_wd[edge_n + 2] = run_cnt;
        exp_hb[edge_n + 2] = run_blk;
      end
      run_len = 0; run_cnt = 0; run_blk = 0; run_prev = 1'b0;
    end
  endtask

  task automatic tick(input bit rst, input bit hs, input bit de,
                      input int r, input int g, input int b, input int th);
    rst_i = rst; hs_i = hs; de_i = de;
    r_i = 8'(r); g_i = 8'(g); b_i = 8'(b); th_i = 8'(th);
    @(posedge clk);
    edge_n++;
    hist_rst[edge_n] = rst;
    hist_de[edge_n]  = de;
    hist_hs[edge_n]  = hs;
    model_step(rst, hs, de, r, g, b, th);
    #1;
  endtask

  task automatic pix(input int r, input int g, input int b);
    tick(1'b0, 1'b0, 1'b1, r, g, b, th_drv);
    px_edge.push_back(edge_n);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 0, 0, 0, th_drv);
  endtask

  task automatic hs_pulse(input int th);
    th_drv = th;
    repeat (2) tick(1'b0, 1'b1, 1'b0, 0, 0, 0, th_drv);
    idle(2);
  endtask

  task automatic clear_obs();
    obs_wd.delete(); obs_hb.delete(); obs_edge.delete(); px_edge.delete();
  endtask

  // Per-cycle compare against the model and the recorded input history
  always @(negedge clk) begin
    bit masked, ev;
    if (edge_n > 0) begin
      masked = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (!hist_rst.exists(edge_n - k) || hist_rst[edge_n - k]) masked = 1'b1;
      end
      chk("de_o", int'(de_o), masked ? 0 : int'(hist_de[edge_n - 2]));
      chk("hs_o", int'(hs_o), masked ? 0 : int'(hist_hs[edge_n - 2]));
      ev = exp_wd.exists(edge_n);
      chk("wd_vld_o", int'(wd_vld_o), int'(ev));
      if (ev) begin
        chk("wd_o", int'(wd_o), exp_wd[edge_n]);
        chk("hb_o", int'(hb_o), exp_hb[edge_n]);
      end
      if (wd_vld_o) begin
        obs_wd.push_back(int'(wd_o));
        obs_hb.push_back(int'(hb_o));
        obs_edge.push_back(edge_n);
      end
    end
  end

  initial begin
    // reset state
    repeat (3) tick(1'b1, 1'b0, 1'b0, 0, 0, 0, th_drv);
    chk("rst_wd", int'(wd_o), 0);
    chk("rst_hb", int'(hb_o), 0);
    chk("rst_vld", int'(wd_vld_o), 0);
    chk("rst_de", int'(de_o), 0);
    chk("rst_hs", int'(hs_o), 0);

    // reset threshold TH=96: luma 95 dark, luma 96 not
    clear_obs();
    for (int i = 0; i < 10; i++) pix(95, 95, 95);
    for (int i = 0; i < 10; i++) pix(96, 96, 96);
    idle(5);
    chk("threset_n", obs_wd.size(), 2);
    chk("threset_b0", qget(obs_wd, 0), 10);
    chk("threset_b1", qget(obs_wd, 1), 0);

    // 20 black pixels: two full blocks, first strobe 3 cycles after pixel 9
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 20; i++) pix(0, 0, 0);
    idle(5);
    chk("black_n", obs_wd.size(), 2);
    chk("black_wd0", qget(obs_wd, 0), 10);
    chk("black_hb0", qget(obs_hb, 0), 0);
    chk("black_wd1", qget(obs_wd, 1), 10);
    chk("black_hb1", qget(obs_hb, 1), 1);
    chk("black_lat", qget(obs_edge, 0), px_edge[9] + 2);

    // white line: no dark pixels
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 20; i++) pix(255, 255, 255);
    idle(5);
    chk("white_n", obs_wd.size(), 2);
    chk("white_wd0", qget(obs_wd, 0), 0);
    chk("white_wd1", qget(obs_wd, 1), 0);

    // alternating black/white: 5 per block
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) pix(0, 0, 0); else pix(255, 255, 255);
    end
    idle(5);
    chk("alt_wd0", qget(obs_wd, 0), 5);
    chk("alt_wd1", qget(obs_wd, 1), 5);

    // 25-pixel line: 10, 10, then flush of 5 one cycle after stage-2 de fall
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 25; i++) pix(0, 0, 0);
    idle(5);
    chk("flush_n", obs_wd.size(), 3);
    chk("flush_wd", qget(obs_wd, 2), 5);
    chk("flush_hb", qget(obs_hb, 2), 2);
    chk("flush_t", qget(obs_edge, 2), px_edge[24] + 3);

    // threshold change mid-line takes effect only from next hs rise
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 5; i++) pix(150, 150, 150);
    th_drv = 200;
    for (int i = 0; i < 5; i++) pix(150, 150, 150);
    idle(3);
    hs_pulse(200);
    for (int i = 0; i < 10; i++) pix(150, 150, 150);
    idle(5);
    chk("thchg_old", qget(obs_wd, 0), 0);
    chk("thchg_new", qget(obs_wd, 1), 10);

    // hysteresis: luma 100 after a dark pixel at th=96
    hs_pulse(96);
    clear_obs();
    pix(0, 0, 0);
    for (int i = 0; i < 9; i++) pix(100, 100, 100);
    idle(5);
`ifdef BLK_VOTE_HYST_EN
    chk("hyst_wd", qget(obs_wd, 0), 10);
`else
    chk("hyst_wd", qget(obs_wd, 0), 1);
`endif

    // reset after 7 pixels: no strobe, fresh start at hb 0
    hs_pulse(96);
    clear_obs();
    for (int i = 0; i < 7; i++) pix(0, 0, 0);
    repeat (2) tick(1'b1, 1'b0, 1'b0, 0, 0, 0, th_drv);
    idle(4);
    chk("rstmid_none", obs_wd.size(), 0);
    for (int i = 0; i < 10; i++) pix(0, 0, 0);
    idle(5);
    chk("rstmid_n", obs_wd.size(), 1);
    chk("rstmid_wd", qget(obs_wd, 0), 10);
    chk("rstmid_hb", qget(obs_hb, 0), 0);

    // randomized lines, hs occasionally overlapping active pixels
    for (int l = 0; l < 60; l++) begin
      int len, gap, v;
      bit h;
      if ($urandom_range(0, 2) == 0) th_drv = $urandom_range(30, 230);
      len = $urandom_range(1, 38);
      for (int p = 0; p < len; p++) begin
        h = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 1) == 1) begin
          v = $urandom_range(0, 255);
          tick(1'b0, h, 1'b1, v, v, v, th_drv);
        end else begin
          tick(1'b0, h, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), th_drv);
        end
      end
      gap = $urandom_range(1, 5);
      for (int k = 0; k < gap; k++) begin
        h = ($urandom_range(0, 2) == 0);
        tick(1'b0, h, 1'b0, 0, 0, 0, th_drv);
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blk_vote_gen.md
Name: blk_vote_gen

Overview:
- Writer side of the per-block vote path: converts the incoming RGB pixel stream into one 8-bit dark-pixel count per horizontal block of KH pixels.
- Emits one vote word per block, plus the block index and a timing-aligned copy of hs/de, for the block accumulation stage downstream.
- Sits between the video input timing and the per-block decision buffer.

Parameters:
- HP, 1920, active pixels per line
- KH, 10, pixels per horizontal block; legal range 1..255
- TH, 96, default luma threshold, loaded into th_r at reset

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active-high
- hs_i  in  1  horizontal sync
- de_i  in  1  data enable, active pixel
- r_i  in  8  red
- g_i  in  8  green
- b_i  in  8  blue
- th_i  in  8  runtime luma threshold, sampled on hs_i rising edge
- hs_o  out  1  hs_i delayed by LAT=3
- de_o  out  1  de_i delayed by LAT=3
- wd_o  out  8  dark-pixel count of the completed block
- wd_vld_o  out  1  one-cycle strobe; wd_o/hb_o valid
- hb_o  out  16  index of the block in wd_o, 0-based within the line

Behaviour:
- Reset values:
  - hs_o=0, de_o=0, wd_o=0, wd_vld_o=0, hb_o=0.
  - th_r=TH, all pipeline stages cleared.
  - Reset mid-line discards the partial block; no strobe for it.
- Threshold update:
  - On hs_i 0->1, th_r <= th_i.
  - A new value takes effect from the next pixel entering stage 1.
  - The same value therefore applies to the whole following line.
- Stage 1:
  - Compute products r*77, g*150, b*29, each 16 bits.
  - Register the products together with de/hs.
- Stage 2:
  - luma = (sum of the three products) >> 8; sum is 18 bits, luma 8 bits.
  - dark = de && (luma < th_r).
- Stage 3 (accumulator):
  - cnt counts dark pixels, 8 bits.
  - h_cur is the 0..KH-1 pixel-in-block counter.
  - On the last pixel of a block (h_cur==KH-1, de stage 2 high):
    - wd_o <= cnt + dark, wd_vld_o <= 1, hb_o <= hb_cur.
    - cnt <= 0, h_cur <= 0, hb_cur++.
- Latency:
  - A block's last pixel presented at cycle t gives wd_vld_o at t+3.
  - de_o/hs_o carry the same 3-cycle delay, so the strobe coincides with de_o of that last pixel.
- Line end (stage-2 de falling edge):
  - If h_cur != 0, flush the partial block: wd_vld_o=1 with the partial count and the current hb_cur.
  - In all cases, h_cur, cnt and hb_cur <= 0.
  - When HP is a multiple of KH, no flush occurs.
- de gaps inside a line:
  - h_cur, cnt and hb_cur hold their values.
  - The falling edge of de is treated as line end.
- Simultaneous hs rise and de: the threshold update and accumulation are independent; both happen.
- Arithmetic:
  - cnt never exceeds KH<=255, so no overflow.
  - hb_cur is 16 bits and wraps mod 2^16; it must not be reached for legal HP.
- wd_vld_o is high for exactly one cycle per block and is never asserted while de_o=0, except for the flush cycle.

Optional Feature:
- Macro BLK_VOTE_HYST_EN.
- Defined:
  - Hysteresis pixel classification: dark = luma < th_r, or luma < th_r+16 (saturating at 255) while the previous active pixel in the same line was dark.
  - The previous-pixel flag clears at line end and on reset.
- Undefined: plain dark = luma < th_r; no extra state.

Decomposition:
- Shared package blk_pkg:
  - LUMA_KR=77, LUMA_KG=150, LUMA_KB=29, LAT=3, HYST_DELTA=16.
  - Typedefs: vote word (8 bits), block index (16 bits).
- One sub-module, luma_pipe: the 2-stage RGB->luma multiplier/adder with matched de/hs delay, reusable elsewhere.
- Accumulator and flush logic stay in blk_vote_gen.

Test Plan:
- Reset, then KH=10, th_i=96, line of 20 pixels all RGB=0 -> two strobes: wd_o=10 with hb_o=0, wd_o=10 with hb_o=1; first strobe 3 cycles after pixel 9.
- Line of RGB=255 -> wd_o=0 for every block; strobe count = HP/KH.
- Alternating pixels 0/255 -> wd_o=5 per block; with BLK_VOTE_HYST_EN and luma 100 after a dark pixel at th=96 -> classified dark.
- HP=25, KH=10 -> strobes of 10, 10, then a flush with partial count 5 and hb_o=2 one cycle after the stage-2 de fall.
- th_i changed from 96 to 200 mid-line, applied at the next hs rise; pixel luma 150 -> not dark on the current line, dark on the next.
- rst_i asserted after 7 pixels of a block -> no strobe; after release, the next line starts at hb_o=0 with fresh counts.
